alert_scheduler: RTL

Shares the single buzzer/alarm output of the pill bottling system between several alert requesters, such as bottle full, batch complete, hopper empty and jam fault. It latches each request and serves the highest-priority one with a source-specific tone and a fixed beep pattern. It sits between the counting/fault logic and the buzzer pin, and replaces direct per-event buzzer drive.

---
 rtl/alert_pkg.sv | 16 +
 rtl/alert_scheduler_tone_gen.sv | 35 +++
 rtl/alert_scheduler.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/alert_pkg.sv
// alert_pkg: shared types for the alert scheduler.
// Holds the sequencer state encoding and the index-width helper.
package alert_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        TONE = 2'd1,
        GAP  = 2'd2
    } state_t;

    // Width of an index able to address n items; never narrower than 1 bit.
    function automatic int src_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/alert_scheduler_tone_gen.sv
// tone_gen: square-wave generator for the alert buzzer.
// The output toggles every half_period enabled cycles; restart forces
// phase 0 (counter cleared, output low) so each beep starts identically.
module tone_gen #(
    parameter int DIV_W = 20
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             restart,
    input  logic [DIV_W-1:0] half_period,
    output logic             tone
);

    logic [DIV_W-1:0] cnt;

    // Half-period counter and toggle flop; restart has priority over counting.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt  <= '0;
            tone <= 1'b0;
        end else if (restart) begin
            cnt  <= '0;
            tone <= 1'b0;
        end else if (en) begin
            if (cnt >= half_period - DIV_W'(1)) begin
                cnt  <= '0;
                tone <= ~tone;
            end else begin
                cnt <= cnt + DIV_W'(1);
            end
        end
    end

endmodule

// File: rtl/alert_scheduler.sv
// alert_scheduler: shares the single buzzer/alarm output between N_SRC
// latched alert requesters. Index 0 has the highest priority; each grant
// plays NBEEP beeps with a source-specific tone pitch.
// Optional feature macro: ALERT_PREEMPT_EN -- a lower-index pending request
// aborts the burst in progress; the aborted source is re-queued.
module alert_scheduler
    import alert_pkg::*;
#(
    parameter int N_SRC    = 4,
    parameter int DIV_W    = 20,
    parameter int BASE_DIV = 2500,
    parameter int TONE_CYC = 50000,
    parameter int GAP_CYC  = 25000,
    parameter int NBEEP    = 3
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [N_SRC-1:0]           req,
    input  logic [N_SRC-1:0]           clr,
    input  logic                       mute,
    output logic                       alarm,
    output logic                       buzzer,
    output logic [src_w(N_SRC)-1:0]    active_src,
    output logic                       done,
    output logic [N_SRC-1:0]           pending
);

    localparam int SRC_W   = src_w(N_SRC);
    localparam int CYC_MAX = (TONE_CYC > GAP_CYC) ? TONE_CYC : GAP_CYC;
    localparam int CYC_W   = $clog2(CYC_MAX + 1);
    localparam int BEEP_W  = src_w(NBEEP);

    localparam logic [CYC_W-1:0]  TONE_LAST = CYC_W'(TONE_CYC - 1);
    localparam logic [CYC_W-1:0]  GAP_LAST  = CYC_W'(GAP_CYC - 1);
    localparam logic [BEEP_W-1:0] BEEP_LAST = BEEP_W'(NBEEP - 1);

    state_t             state, state_nxt;
    logic [SRC_W-1:0]   src_nxt;
    logic [SRC_W-1:0]   sel;
    logic               sel_vld;
    logic [N_SRC-1:0]   cand;
    logic [N_SRC-1:0]   pend_nxt;
    logic [CYC_W-1:0]   cyc_cnt, cyc_nxt;
    logic [BEEP_W-1:0]  beep_cnt, beep_nxt;
    logic               done_nxt;
    logic               tone_restart;
    logic               tone;
    logic               preempt;
    logic               abort;
    logic [DIV_W-1:0]   half_period;

    // Lowest-set-bit priority encoder over requests not being cancelled this cycle.
    always_comb begin
        cand    = pending & ~clr;
        sel_vld = |cand;
        sel     = '0;
        for (int i = N_SRC - 1; i >= 0; i--) begin
            if (cand[i]) sel = SRC_W'(i);
        end
    end

`ifdef ALERT_PREEMPT_EN
    // Any waiting request with a smaller index than the one being served wins the buzzer.
    always_comb begin
        preempt = 1'b0;
        for (int i = 0; i < N_SRC; i++) begin
            if (cand[i] && (SRC_W'(i) < active_src)) preempt = 1'b1;
        end
    end
`else
    assign preempt = 1'b0;
`endif

    assign abort = clr[active_src] | preempt;

    // Next-state, counters and pending bookkeeping; a burst abort overrides normal sequencing.
    always_comb begin
        state_nxt    = state;
        src_nxt      = active_src;
        cyc_nxt      = cyc_cnt;
        beep_nxt     = beep_cnt;
        done_nxt     = 1'b0;
        tone_restart = 1'b0;
        pend_nxt     = pending;

        if ((state != IDLE) && abort) begin
            state_nxt = IDLE;
            src_nxt   = '0;
            cyc_nxt   = '0;
            beep_nxt  = '0;
            if (preempt) pend_nxt[active_src] = 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (sel_vld) begin
                        state_nxt     = TONE;
                        src_nxt       = sel;
                        cyc_nxt       = '0;
                        beep_nxt      = '0;
                        tone_restart  = 1'b1;
                        pend_nxt[sel] = 1'b0;
                    end
                end
                TONE: begin
                    if (cyc_cnt == TONE_LAST) begin
                        cyc_nxt = '0;
                        if (beep_cnt == BEEP_LAST) begin
                            state_nxt = IDLE;
                            src_nxt   = '0;
                            beep_nxt  = '0;
                            done_nxt  = 1'b1;
                        end else begin
                            state_nxt = GAP;
                            beep_nxt  = beep_cnt + BEEP_W'(1);
                        end
                    end else begin
                        cyc_nxt = cyc_cnt + CYC_W'(1);
                    end
                end
                GAP: begin
                    if (cyc_cnt == GAP_LAST) begin
                        state_nxt    = TONE;
                        cyc_nxt      = '0;
                        tone_restart = 1'b1;
                    end else begin
                        cyc_nxt = cyc_cnt + CYC_W'(1);
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end

        // New requests latch on top of any grant/re-queue; cancel always wins.
        pend_nxt = (pend_nxt | req) & ~clr;
    end

    // State, counters, pending latch and the done pulse register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            active_src <= '0;
            cyc_cnt    <= '0;
            beep_cnt   <= '0;
            pending    <= '0;
            done       <= 1'b0;
        end else begin
            state      <= state_nxt;
            active_src <= src_nxt;
            cyc_cnt    <= cyc_nxt;
            beep_cnt   <= beep_nxt;
            pending    <= pend_nxt;
            done       <= done_nxt;
        end
    end

    // Pitch drops with priority: half period scales with (source index + 1).
    assign half_period = DIV_W'(BASE_DIV * (int'(active_src) + 1));

    tone_gen #(
        .DIV_W (DIV_W)
    ) u_tone_gen (
        .clk         (clk),
        .rst_n       (rst_n),
        .en          (state == TONE),
        .restart     (tone_restart),
        .half_period (half_period),
        .tone        (tone)
    );

    assign alarm  = (state != IDLE);
    assign buzzer = tone & (state == TONE) & ~mute;

endmodule
